// File: rtl/lab_common_pkg.sv
// lab_common: shared lab constants and the debounce FSM state encoding.
package lab_common;
    localparam int DEBOUNCE_10MS_100MHZ = 1000000;
    typedef enum logic [1:0] {
        S_LO      = 2'd0,
        S_WAIT_HI = 2'd1,
        S_HI      = 2'd2,
        S_WAIT_LO = 2'd3
    } state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous level, reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic s1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end
endmodule

// File: rtl/debounce.sv
// debounce: synchronizes a raw button and only follows a level held for STABLE_CYCLES samples.
module debounce
    import lab_common::*;
#(
    parameter int STABLE_CYCLES = DEBOUNCE_10MS_100MHZ,
    parameter int CNT_W         = 20,
    parameter int GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                button_in,
    input  logic                clr_glitch,
    output logic                debounce_out,
    output logic                settling,
    output logic [GLITCH_W-1:0] glitch_cnt
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
    if (STABLE_CYCLES < 2 || ((STABLE_CYCLES - 1) >> CNT_W) != 0) begin : g_param_err
        $error("debounce: need STABLE_CYCLES >= 2 and 2**CNT_W > STABLE_CYCLES-1");
    end
    logic             s2;
    logic             abort;
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (button_in),
        .q     (s2)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_LO;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end
    // cnt counts consecutive samples at the candidate level, starting at 1 on entry
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        abort    = 1'b0;
        unique case (state)
            S_LO: if (s2) begin
                state_nx = S_WAIT_HI;
                cnt_nx   = CNT_W'(1);
            end
            S_WAIT_HI: if (!s2) begin
                state_nx = S_LO;
                cnt_nx   = '0;
                abort    = 1'b1;
            end else if (cnt == LAST) begin
                state_nx = S_HI;
                cnt_nx   = '0;
            end else cnt_nx = cnt + 1'b1;
            S_HI: if (!s2) begin
                state_nx = S_WAIT_LO;
                cnt_nx   = CNT_W'(1);
            end
            S_WAIT_LO: if (s2) begin
                state_nx = S_HI;
                cnt_nx   = '0;
                abort    = 1'b1;
            end else if (cnt == LAST) begin
                state_nx = S_LO;
                cnt_nx   = '0;
            end else cnt_nx = cnt + 1'b1;
        endcase
    end
    assign debounce_out = (state == S_HI) || (state == S_WAIT_LO);
    assign settling     = (state == S_WAIT_HI) || (state == S_WAIT_LO);
    // clear has priority over a coincident abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) glitch_cnt <= '0;
        else if (clr_glitch) glitch_cnt <= '0;
        else if (abort && glitch_cnt != '1) glitch_cnt <= glitch_cnt + 1'b1;
    end
endmodule

// File: tb/tb_debounce.sv
// tb_debounce: scoreboard bench; stimulus queues expected states, a negedge monitor compares.
module tb_debounce;
    import lab_common::*;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       button_in = 1'b0;
    logic       clr_glitch = 1'b0;
    logic       debounce_out;
    logic       settling;
    logic [1:0] glitch_cnt;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         pulses = 0;
    logic       prev_out = 1'b0;
    typedef struct {
        int         t;
        logic       o;
        logic       s;
        logic [1:0] g;
        state_t     st;
        int         c;
        string      name;
    } exp_t;
    exp_t sb[$];
    exp_t m;
    debounce #(.STABLE_CYCLES(4), .CNT_W(3), .GLITCH_W(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .button_in    (button_in),
        .clr_glitch   (clr_glitch),
        .debounce_out (debounce_out),
        .settling     (settling),
        .glitch_cnt   (glitch_cnt)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // d = number of edges from now; d=e+1 means "after edge e" with edge 0 the next edge
    task automatic chk(input int d, input logic o, input logic s, input logic [1:0] g,
                       input state_t st, input int c, input string name);
        exp_t e;
        e.t = cyc + d; e.o = o; e.s = s; e.g = g; e.st = st; e.c = c; e.name = name;
        sb.push_back(e);
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].t <= cyc) begin
            m = sb.pop_front();
            n_checks++;
            if (m.t != cyc || debounce_out !== m.o || settling !== m.s || glitch_cnt !== m.g ||
                dut.state !== m.st || (m.c >= 0 && int'(dut.cnt) != m.c)) begin
                n_fail++;
                $display("FAIL %s cyc %0d (due %0d): out=%b want %b, settling=%b want %b, glitch=%0d want %0d, state=%0d want %0d, cnt=%0d want %0d",
                         m.name, cyc, m.t, debounce_out, m.o, settling, m.s, glitch_cnt, m.g,
                         dut.state, m.st, dut.cnt, m.c);
            end
        end
        if (debounce_out && !prev_out) pulses++;
        prev_out = debounce_out;
    end
    initial begin
        tick(2);
        chk(0, 0, 0, 0, S_LO, 0, "in_reset");
        tick(1);
        rst_n = 1'b1;
        chk(0, 0, 0, 0, S_LO, 0, "reset_release");
        tick(2);
        // clean press
        button_in = 1'b1;
        chk(2, 0, 0, 0, S_LO, 0, "t1_sync_delay");
        chk(3, 0, 1, 0, S_WAIT_HI, 1, "t1_settling");
        chk(5, 0, 1, 0, S_WAIT_HI, 3, "t1_before_out");
        chk(6, 1, 0, 0, S_HI, 0, "t1_out_high");
        tick(8);
        // low for exactly STABLE_CYCLES edges passes, then back high
        button_in = 1'b0;
        chk(2, 1, 0, 0, S_HI, 0, "t3_hold");
        chk(3, 1, 1, 0, S_WAIT_LO, 1, "t3_settle_lo");
        chk(6, 0, 0, 0, S_LO, 0, "t3_exact_low");
        chk(7, 0, 1, 0, S_WAIT_HI, 1, "t3_rearm");
        chk(10, 1, 0, 0, S_HI, 0, "t3_back_high");
        tick(4);
        button_in = 1'b1;
        tick(8);
        // low pulse one edge short is rejected
        button_in = 1'b0;
        chk(5, 1, 1, 0, S_WAIT_LO, 3, "t3_short_wait");
        chk(6, 1, 0, 1, S_HI, 0, "t3_short_reject");
        tick(3);
        button_in = 1'b1;
        tick(5);
        button_in = 1'b0;
        chk(6, 0, 0, 1, S_LO, 0, "t3_release");
        tick(8);
        // bounce: 3 high samples then low
        button_in = 1'b1;
        chk(5, 0, 1, 1, S_WAIT_HI, 3, "t2_wait");
        chk(6, 0, 0, 2, S_LO, 0, "t2_reject");
        tick(3);
        button_in = 1'b0;
        tick(5);
        // aborts up to and past saturation
        for (int i = 0; i < 3; i++) begin
            button_in = 1'b1;
            chk(4, 0, 0, 3, S_LO, 0, i == 0 ? "t4_abort" : "t4_saturated");
            tick(1);
            button_in = 1'b0;
            tick(4);
        end
        // clear coincident with an abort wins
        button_in = 1'b1;
        chk(3, 0, 1, 3, S_WAIT_HI, 1, "t4_pre_clear");
        chk(4, 0, 0, 0, S_LO, 0, "t4_clear_wins");
        tick(1);
        button_in = 1'b0;
        tick(2);
        clr_glitch = 1'b1;
        tick(1);
        clr_glitch = 1'b0;
        tick(3);
        // reset mid-settle is immediate and discards the partial count
        button_in = 1'b1;
        chk(3, 0, 1, 0, S_WAIT_HI, 1, "t5_settling");
        tick(4);
        rst_n = 1'b0;
        chk(0, 0, 0, 0, S_LO, 0, "t5_async_reset");
        tick(2);
        rst_n = 1'b1;
        chk(5, 0, 1, 0, S_WAIT_HI, 3, "t5_full_latency");
        chk(6, 1, 0, 0, S_HI, 0, "t5_out_high");
        tick(8);
        // reset released with input already high
        rst_n = 1'b0;
        chk(0, 0, 0, 0, S_LO, 0, "t6_reset");
        tick(2);
        rst_n = 1'b1;
        pulses = 0;
        chk(5, 0, 1, 0, S_WAIT_HI, -1, "t6_before_out");
        chk(6, 1, 0, 0, S_HI, 0, "t6_out_high");
        tick(12);
        n_checks++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL t6_one_pulse: got %0d rising edges, want 1", pulses);
        end
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations never checked", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
